// File: rtl/cayde_pkg.sv
// cayde core shared types: memory op encodings and LSU state/size helpers.
package cayde_pkg;

  typedef enum logic [1:0] {
    LOAD_BYTE_U      = 2'd0,
    LOAD_HALF_WORD_U = 2'd1,
    LOAD_WORD        = 2'd2
  } load_op;

  typedef enum logic [1:0] {
    STORE_BYTE      = 2'd0,
    STORE_HALF_WORD = 2'd1,
    STORE_WORD      = 2'd2
  } store_op;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } lsu_size_e;

  localparam int LSU_TIMEOUT_DEFAULT = 16;

  function automatic lsu_size_e op_size(
    logic    we,
    load_op  lop,
    store_op sop
  );
    lsu_size_e s;
    s = SZ_BAD;
    if (we) begin
      case (sop)
        STORE_BYTE:      s = SZ_BYTE;
        STORE_HALF_WORD: s = SZ_HALF;
        STORE_WORD:      s = SZ_WORD;
        default:         s = SZ_BAD;
      endcase
    end else begin
      case (lop)
        LOAD_BYTE_U:      s = SZ_BYTE;
        LOAD_HALF_WORD_U: s = SZ_HALF;
        LOAD_WORD:        s = SZ_WORD;
        default:          s = SZ_BAD;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/cayde_lsu_align.sv
// Byte-lane logic for the LSU: enables, store replication,
// load extraction and alignment trap detection.
module cayde_lsu_align
  import cayde_pkg::*;
(
  input  logic        we_i,
  input  load_op      load_op_i,
  input  store_op     store_op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);

  lsu_size_e size;

  assign size = op_size(we_i, load_op_i, store_op_i);

  always_comb begin
    be_o         = '0;
    wdata_o      = '0;
    rdata_o      = '0;
    misaligned_o = 1'b0;
    case (size)
      SZ_BYTE: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {24'h0, rdata_i[{off_i, 3'b000} +: 8]};
      end
      SZ_HALF: begin
        misaligned_o = off_i[0];
        be_o         = 4'b0011 << off_i;
        wdata_o      = {2{wdata_i[15:0]}};
        rdata_o      = {16'h0, rdata_i[{off_i[1], 4'b0000} +: 16]};
      end
      SZ_WORD: begin
        misaligned_o = |off_i;
        be_o         = 4'b1111;
        wdata_o      = wdata_i;
        rdata_o      = rdata_i;
      end
      // unknown encodings trap and never reach the bus
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/cayde_lsu.sv
// cayde load/store unit: sequences one data-bus access per request
// and stalls the core until completion, trap or timeout.
module cayde_lsu
  import cayde_pkg::*;
#(
  parameter int TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req_in,
  input  logic        lsu_we_in,
  input  load_op      load_op_in,
  input  store_op     store_op_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        lsu_busy_out,
  output logic        lsu_done_out,
  output logic [31:0] rdata_out,
  output logic        misaligned_out,
  output logic        bus_err_out,
  output logic        data_req_out,
  input  logic        data_gnt_in,
  output logic [31:0] data_addr_out,
  output logic        data_we_out,
  output logic [3:0]  data_be_out,
  output logic [31:0] data_wdata_out,
  input  logic        data_rvalid_in,
  input  logic [31:0] data_rdata_in
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state    state_q, state_d;
  logic        we_q, we_d;
  load_op      lop_q, lop_d;
  store_op     sop_q, sop_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        mis_q, mis_d;
  logic        berr_q, berr_d;
  logic [31:0] rdata_q, rdata_d;

  logic        idle, in_req;
  logic        a_we;
  load_op      a_lop;
  store_op     a_sop;
  logic [1:0]  a_off;
  logic [31:0] a_wdata;
  logic [3:0]  a_be;
  logic [31:0] a_wrep;
  logic [31:0] a_rext;
  logic        a_mis;

  assign idle   = (state_q == IDLE);
  assign in_req = (state_q == REQ);

  // in IDLE the trap check looks at the live request, later at the latched op
  assign a_we    = idle ? lsu_we_in   : we_q;
  assign a_lop   = idle ? load_op_in  : lop_q;
  assign a_sop   = idle ? store_op_in : sop_q;
  assign a_off   = idle ? addr_in[1:0] : addr_q[1:0];
  assign a_wdata = idle ? wdata_in    : wdata_q;

  cayde_lsu_align u_align (
    .we_i         (a_we),
    .load_op_i    (a_lop),
    .store_op_i   (a_sop),
    .off_i        (a_off),
    .wdata_i      (a_wdata),
    .rdata_i      (data_rdata_in),
    .be_o         (a_be),
    .wdata_o      (a_wrep),
    .rdata_o      (a_rext),
    .misaligned_o (a_mis)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    lop_d   = lop_q;
    sop_d   = sop_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    berr_d  = berr_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (lsu_req_in) begin
          we_d    = lsu_we_in;
          lop_d   = load_op_in;
          sop_d   = store_op_in;
          addr_d  = addr_in;
          wdata_d = wdata_in;
          mis_d   = a_mis;
          berr_d  = 1'b0;
          state_d = a_mis ? DONE : REQ;
        end
      end
      REQ: begin
        if (data_gnt_in) begin
          cnt_d   = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (data_rvalid_in) begin
          if (!we_q) rdata_d = a_rext;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          berr_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      lop_q   <= LOAD_BYTE_U;
      sop_q   <= STORE_BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      lop_q   <= lop_d;
      sop_q   <= sop_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
      rdata_q <= rdata_d;
    end
  end

  assign lsu_busy_out   = !idle;
  assign lsu_done_out   = (state_q == DONE);
  assign misaligned_out = lsu_done_out & mis_q;
  assign bus_err_out    = lsu_done_out & berr_q;
  assign rdata_out      = rdata_q;
  assign data_req_out   = in_req;
  assign data_addr_out  = in_req ? {addr_q[31:2], 2'b00} : '0;
  assign data_we_out    = in_req & we_q;
  assign data_be_out    = in_req ? a_be : '0;
  assign data_wdata_out = in_req ? a_wrep : '0;

endmodule

// File: doc/cayde_lsu.md
# cayde_lsu

Load/store unit controller for the cayde RISC-V core. It takes a decoded memory operation (`load_op` or `store_op` from the decoder) with its effective address and store data. It sequences one access on the core's data-memory request/grant/response bus, handling byte-enable generation, store-data lane replication, load-data extraction with zero-extension, misalignment trapping and a response timeout. It sits between the execute stage and the data memory port and stalls the core while an access is outstanding.

## Interface
- `TIMEOUT`, 16: max cycles waiting for `data_rvalid_in` after grant before aborting with a bus error.
- `clk` in 1: core clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `lsu_req_in` in 1: core requests a memory op; sampled only in IDLE.
- `lsu_we_in` in 1: 1 = store (`store_op_in` valid), 0 = load (`load_op_in` valid).
- `load_op_in` in `cayde_pkg::load_op`: LOAD_BYTE_U / LOAD_HALF_WORD_U / LOAD_WORD.
- `store_op_in` in `cayde_pkg::store_op`: STORE_BYTE / STORE_HALF_WORD / STORE_WORD.
- `addr_in` in 32: effective byte address.
- `wdata_in` in 32: store data, right-aligned.
- `lsu_busy_out` out 1: stall to core.
- `lsu_done_out` out 1: one-cycle completion pulse.
- `rdata_out` out 32: load result, zero-extended, valid with `lsu_done_out`.
- `misaligned_out` out 1: qualifies `lsu_done_out`; access trapped, no bus activity.
- `bus_err_out` out 1: qualifies `lsu_done_out`; timeout expired.
- `data_req_out` out 1, `data_gnt_in` in 1: request/grant handshake.
- `data_addr_out` out 32: word-aligned address ({addr[31:2],2'b00}).
- `data_we_out` out 1, `data_be_out` out 4, `data_wdata_out` out 32.
- `data_rvalid_in` in 1, `data_rdata_in` in 32: response, for loads and stores alike.

## Operation
- States: IDLE, REQ, RESP, DONE.
- IDLE: on `lsu_req_in`, register op, we, addr, wdata.
  - If misaligned (half with addr[0]=1; word with addr[1:0]!=0), go to DONE with misaligned flag.
  - Otherwise go to REQ.
- REQ: `data_req_out`=1 with stable addr/we/be/wdata until `data_gnt_in`, then go to RESP and clear the timeout counter.
- RESP: wait for `data_rvalid_in`. On rvalid, capture the extracted load data (loads only) and go to DONE. If the counter reaches TIMEOUT-1 without rvalid, go to DONE with bus_err.
- DONE: pulse `lsu_done_out` with the flags, then return to IDLE.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
- Store data: byte replicated to all 4 lanes; half replicated to 2 lanes; word passed through.
- Load data: lane selected by addr[1:0]; byte and half zero-extended to 32 bits.
- rvalid outside RESP (IDLE, REQ, or same cycle as gnt) is ignored. The bus must return rvalid ≥1 cycle after gnt.
- Unknown op encodings are treated as misaligned (trap), never issued to the bus.

## Timing
- Reset values: state IDLE, all outputs 0 including `rdata_out`, counter 0.
- `lsu_busy_out` = (state != IDLE). It is registered-state based, so the request cycle itself shows busy=0 and busy rises on the next cycle.
- `data_req_out` rises 1 cycle after acceptance.
- Latency with immediate grant and rvalid the next cycle: accept at cycle 0, req/gnt at cycle 1, rvalid at cycle 2, done at cycle 3.
- Misaligned access: done at cycle 1, no req.
- Timeout: done at cycle g+TIMEOUT+1, where g is the grant cycle.
- `rdata_out` holds its value until the next load completes. Stores and errors leave it unchanged.
- Reset mid-operation: immediate return to IDLE with `data_req_out` dropped asynchronously. A pending response is discarded.
- `lsu_req_in` asserted in DONE is not accepted; the core re-presents it in IDLE.

## Structure
- `cayde_pkg` additions:
  - `lsu_state` enum (IDLE/REQ/RESP/DONE).
  - `LSU_TIMEOUT_DEFAULT` = 16.
  - Reuse of the existing `load_op` and `store_op` types.
- Sub-module `cayde_lsu_align` (combinational): be, wdata replication, rdata extraction and misalignment detection from op+addr[1:0].
- The FSM, registers and counter live in `cayde_lsu`.

## Test plan
- STORE_WORD addr 0x100, wdata 0xDEADBEEF, gnt immediate, rvalid +1 -> req cycle 1, be=4'b1111, data_addr=0x100, done cycle 3.
- LOAD_BYTE_U addr 0x203, rdata 0x80AB_CDEF -> be=4'b1000, data_addr=0x200, rdata_out=0x00000080.
- STORE_HALF_WORD addr 0x302, wdata 0x0000_1234, gnt delayed 3 cycles -> req held stable 4 cycles, be=4'b1100, wdata=0x1234_1234.
- LOAD_WORD addr 0x101 -> done+misaligned at cycle 1, data_req_out never asserted, rdata_out unchanged.
- LOAD_WORD, grant, no rvalid -> done+bus_err after 16 cycles in RESP; a late rvalid in IDLE is ignored.
- Reset asserted in RESP -> all outputs 0 immediately; the next request completes normally.
